// File: rtl/vmicro16_apb_pkg.sv
// Shared APB definitions for vmicro16: bus width default and the initiator
// state encoding used by the bridge, slave peripherals and interconnect.
package vmicro16_apb_pkg;

    localparam int APB_BUS_WIDTH = 16;

    localparam logic [1:0] APB_IDLE   = 2'd0;
    localparam logic [1:0] APB_SETUP  = 2'd1;
    localparam logic [1:0] APB_ACCESS = 2'd2;

endpackage

// File: rtl/apb_watchdog.sv
// Saturating PREADY watchdog: counts stalled ACCESS cycles and flags the
// last cycle a transfer may wait before it is aborted.
module apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // With TIMEOUT_CYCLES == 0 this wraps to all-ones but is masked below.
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SAT   = '1;

    logic [CNT_WIDTH-1:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != SAT)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (r_count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Core-side APB3 initiator: turns one load/store request into a SETUP/ACCESS
// transfer and returns a one-cycle response, aborting hung slaves via a watchdog.
module apb_master_bridge
    import vmicro16_apb_pkg::*;
#(
    parameter int BUS_WIDTH      = APB_BUS_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic [BUS_WIDTH-1:0] M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSELx,
    output logic                 M_PENABLE,
    output logic [BUS_WIDTH-1:0] M_PWDATA,
    input  logic [BUS_WIDTH-1:0] M_PRDATA,
    input  logic                 M_PREADY
);

    logic [1:0] r_state;
    logic       w_accept;
    logic       w_wd_enable;
    logic       w_expired;

    assign req_ready   = (r_state == APB_IDLE);
    assign w_accept    = req_ready && req_valid;
    assign w_wd_enable = (r_state == APB_ACCESS) && !M_PREADY;

    apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (w_wd_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= APB_IDLE;
            M_PADDR    <= '0;
            M_PWDATA   <= '0;
            M_PWRITE   <= 1'b0;
            M_PSELx    <= 1'b0;
            M_PENABLE  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // Defaulting low each cycle makes resp_valid a single-cycle pulse.
            resp_valid <= 1'b0;
            case (r_state)
                APB_IDLE: begin
                    if (req_valid) begin
                        M_PADDR  <= req_addr;
                        M_PWDATA <= req_wdata;
                        M_PWRITE <= req_write;
                        M_PSELx  <= 1'b1;
                        r_state  <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    M_PENABLE <= 1'b1;
                    r_state   <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    // PREADY is tested first so a completion on the expiry cycle wins.
                    if (M_PREADY) begin
                        M_PSELx    <= 1'b0;
                        M_PENABLE  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        if (!M_PWRITE) begin
                            resp_rdata <= M_PRDATA;
                        end
                        r_state    <= APB_IDLE;
                    end else if (w_expired) begin
                        M_PSELx    <= 1'b0;
                        M_PENABLE  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        r_state    <= APB_IDLE;
                    end
                end
                default: begin
                    M_PSELx   <= 1'b0;
                    M_PENABLE <= 1'b0;
                    r_state   <= APB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a transaction-level model predicts
// each response; a monitor compares responses and APB bus behaviour.
module tb_apb_master_bridge;

    localparam int BW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [BW-1:0] req_addr;
    logic [BW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [BW-1:0] resp_rdata;
    logic [BW-1:0] M_PADDR;
    logic          M_PWRITE;
    logic          M_PSELx;
    logic          M_PENABLE;
    logic [BW-1:0] M_PWDATA;
    logic [BW-1:0] M_PRDATA;
    logic          M_PREADY;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .M_PADDR    (M_PADDR),
        .M_PWRITE   (M_PWRITE),
        .M_PSELx    (M_PSELx),
        .M_PENABLE  (M_PENABLE),
        .M_PWDATA   (M_PWDATA),
        .M_PRDATA   (M_PRDATA),
        .M_PREADY   (M_PREADY)
    );

    typedef struct {
        logic          err;
        logic [BW-1:0] rdata;
        int            lat;
        int            pen;
    } exp_t;

    typedef struct {
        int            wt;
        logic [BW-1:0] data;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    acc_q[$];

    int            vectors = 0;
    int            miscompares = 0;
    logic [BW-1:0] model_rdata = '0;
    bit            expect_b2b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slave: each transfer is stalled for plan.wt ACCESS cycles, then completes.
    initial begin
        int    acc_cnt;
        plan_t cur;
        acc_cnt  = 0;
        cur.wt   = 0;
        cur.data = '0;
        M_PREADY = 1'b0;
        M_PRDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !(M_PSELx && M_PENABLE)) begin
                acc_cnt  = 0;
                M_PREADY = 1'($urandom);
                M_PRDATA = 16'($urandom);
            end else begin
                acc_cnt++;
                if (acc_cnt == 1) begin
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                    end else begin
                        cur.wt   = 0;
                        cur.data = '0;
                    end
                end
                M_PREADY = (acc_cnt > cur.wt);
                M_PRDATA = M_PREADY ? cur.data : 16'($urandom);
            end
        end
    end

    // Monitor: checks the bus on the falling edge and scores every response.
    int            cyc = 0;
    int            pen_cnt = 0;
    int            last_resp = -100;
    bit            prev_psel = 1'b0;
    bit            prev_rv = 1'b0;
    logic [BW-1:0] e_addr = '0;
    logic [BW-1:0] e_wdata = '0;
    logic          e_write = 1'b0;
    logic [BW-1:0] held_rdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                acc_q.delete();
                pen_cnt    = 0;
                prev_psel  = 1'b0;
                prev_rv    = 1'b0;
                e_addr     = '0;
                e_wdata    = '0;
                e_write    = 1'b0;
                held_rdata = '0;
            end else begin
                if (M_PENABLE) pen_cnt++;
                check("req_ready_vs_psel", req_ready, !M_PSELx);
                check("apb_paddr", M_PADDR, e_addr);
                check("apb_pwdata", M_PWDATA, e_wdata);
                check("apb_pwrite", M_PWRITE, e_write);
                if (M_PSELx && !prev_psel) check("setup_penable", M_PENABLE, 1'b0);
                if (!M_PSELx) check("idle_penable", M_PENABLE, 1'b0);
                if (prev_psel && !M_PSELx) check("psel_drop_with_resp", resp_valid, 1'b1);
                if (resp_valid) begin
                    check("resp_pulse", prev_rv, 1'b0);
                    check("resp_psel_low", M_PSELx, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("resp_outstanding", exp_q.size(), 1);
                    end else begin
                        exp_t e;
                        int   a;
                        e = exp_q.pop_front();
                        a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                        check("resp_err", resp_err, e.err);
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_latency", cyc - a, e.lat);
                        check("penable_cycles", pen_cnt, e.pen);
                        held_rdata = e.rdata;
                    end
                    pen_cnt   = 0;
                    last_resp = cyc;
                end else begin
                    check("rdata_hold", resp_rdata, held_rdata);
                end
                if (req_valid && req_ready) begin
                    if (expect_b2b) begin
                        check("b2b_accept_cycle", cyc, last_resp);
                        expect_b2b = 1'b0;
                    end
                    acc_q.push_back(cyc);
                    e_addr  = req_addr;
                    e_wdata = req_wdata;
                    e_write = req_write;
                end
                prev_psel = M_PSELx;
                prev_rv   = resp_valid;
            end
        end
    end

    // Presents one request, records its predicted outcome, waits for accept.
    task automatic issue(input logic wr, input logic [BW-1:0] addr, input logic [BW-1:0] wdata,
                         input int wt, input logic [BW-1:0] rd, input bit hold);
        exp_t  e;
        plan_t p;
        int    n;
        p.wt   = wt;
        p.data = rd;
        plan_q.push_back(p);
        if (wt >= TO) begin
            e.err   = 1'b1;
            e.rdata = '0;
            e.lat   = TO + 2;
            e.pen   = TO;
        end else begin
            e.err   = 1'b0;
            e.rdata = wr ? model_rdata : rd;
            e.lat   = wt + 3;
            e.pen   = wt + 1;
        end
        model_rdata = e.rdata;
        exp_q.push_back(e);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 100) begin
                check("accept_wait_bound", req_ready, 1'b1);
                break;
            end
        end
        if (!hold) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "bench aborted");
    end

    initial begin
        int  n;
        bit  prev_hold;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        #12;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_psel", M_PSELx, 1'b0);
        check("reset_penable", M_PENABLE, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_err", resp_err, 1'b0);
        check("reset_resp_rdata", resp_rdata, 16'h0000);
        check("reset_paddr", M_PADDR, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b1, 16'h0090, 16'hBEEF, 0, 16'($urandom), 1'b0);
        issue(1'b0, 16'h00A4, 16'h5555, 2, 16'h1234, 1'b0);
        issue(1'b0, 16'h00B0, 16'h0000, 100, 16'h7777, 1'b0);
        issue(1'b1, 16'h00B2, 16'hCAFE, 1, 16'($urandom), 1'b0);
        issue(1'b0, 16'h00B4, 16'h0000, 3, 16'h00C0, 1'b0);
        issue(1'b1, 16'h0080, 16'hA5A5, 0, 16'($urandom), 1'b1);
        expect_b2b = 1'b1;
        issue(1'b0, 16'h00C0, 16'h0F0F, 1, 16'h4321, 1'b0);

        prev_hold = 1'b0;
        for (int i = 0; i < 150; i++) begin
            int wt;
            bit hold;
            wt   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
            hold = ($urandom_range(0, 3) == 0) && (i != 149);
            if (prev_hold) expect_b2b = 1'b1;
            issue(1'($urandom), 16'($urandom), 16'($urandom), wt, 16'($urandom), hold);
            prev_hold = hold;
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Reset during ACCESS of a transfer that would otherwise time out.
        issue(1'b0, 16'h0123, 16'h0000, 50, 16'h9999, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_psel", M_PSELx, 1'b0);
        check("async_reset_penable", M_PENABLE, 1'b0);
        check("async_reset_resp_valid", resp_valid, 1'b0);
        check("async_reset_req_ready", req_ready, 1'b1);
        exp_q.delete();
        plan_q.delete();
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_req_ready", req_ready, 1'b1);
        check("post_reset_rdata", resp_rdata, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            issue(1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)), 16'($urandom), 1'b0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
